// File: rtl/memory_stage_pkg.sv
// memory_stage shared definitions: writeback-source codes and the
// access FSM state encoding.
package memory_stage_pkg;

  localparam logic [2:0] MEMTOREG_ALU    = 3'b000;
  localparam logic [2:0] MEMTOREG_MEM    = 3'b001;
  localparam logic [2:0] MEMTOREG_PC4    = 3'b010;
  localparam logic [2:0] MEMTOREG_MULTLO = 3'b011;
  localparam logic [2:0] MEMTOREG_MULTHI = 3'b100;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  function automatic logic is_memop(
    input logic       mem_write,
    input logic [2:0] memto_reg
  );
    return mem_write | (memto_reg == MEMTOREG_MEM);
  endfunction

endpackage

// File: rtl/mem_access_fsm.sv
// memory_stage access sequencer: request/stall generation, wait
// counter and timeout for a variable-latency data memory.
module mem_access_fsm
  import memory_stage_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CW      = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic access,
  input  logic ready,
  output logic req,
  output logic stall,
  output logic timeout
);

  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  state_t        state;
  logic [CW-1:0] cnt;

  // The IDLE request cycle is the first stall cycle, so the access is
  // dropped in the WAIT cycle after TIMEOUT stalled cycles.
  always_comb begin
    timeout = (state == ST_WAIT) && (cnt == LAST);
    req     = (state == ST_IDLE) ? access : ~timeout;
    stall   = req & ~ready;
  end

  // State and wait counter; counter is cleared whenever idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (access && !ready) state <= ST_WAIT;
        end
        ST_WAIT: begin
          cnt <= cnt + 1'b1;
          if (timeout || ready) state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/memory_stage.sv
// memory_stage: E->M pipeline register, data-memory port and M->W data.
// Optional misaligned-access trap enabled with MEM_ALIGN_CHK_EN.
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CW      = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jumpE,
  input  logic        RegWriteE,
  input  logic        MemWriteE,
  input  logic [2:0]  MemtoRegE,
  input  logic [4:0]  WriteRegE,
  input  logic [31:0] ALUMultOutE,
  input  logic [31:0] WriteDataE,
  input  logic [31:0] PCPlus4E,
  output logic        jumpM,
  output logic        RegWriteM,
  output logic [2:0]  MemtoRegM,
  output logic [4:0]  WriteRegM,
  output logic [31:0] ALUOutM,
  output logic [31:0] ReadDataM,
  output logic [31:0] PCPlus4M,
  output logic        StallM,
  output logic        MemErrM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready
);

  logic        reg_write_q;
  logic        mem_write_q;
  logic [31:0] write_data_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        memop;
  logic        misalign;
  logic        access;
  logic        load;
  logic        timeout;
  logic        load_done;

  assign memop = is_memop(mem_write_q, MemtoRegM);
  assign load  = (MemtoRegM == MEMTOREG_MEM);

`ifdef MEM_ALIGN_CHK_EN
  assign misalign = memop & (ALUOutM[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  assign access = memop & ~misalign;

  mem_access_fsm #(
    .TIMEOUT(TIMEOUT),
    .CW     (CW)
  ) u_fsm (
    .clk    (clk),
    .rst    (rst),
    .access (access),
    .ready  (dmem_ready),
    .req    (dmem_req),
    .stall  (StallM),
    .timeout(timeout)
  );

  assign load_done  = dmem_req & dmem_ready & load;
  assign dmem_addr  = ALUOutM;
  assign dmem_wdata = write_data_q;
  assign dmem_we    = mem_write_q;
  assign ReadDataM  = load_done ? dmem_rdata : rdata_q;
  assign MemErrM    = err_q;
  assign RegWriteM  = reg_write_q & ~StallM
                    & ~timeout & ~misalign;

  // E->M register: advances whenever the stage is not stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      jumpM        <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      MemtoRegM    <= MEMTOREG_ALU;
      WriteRegM    <= '0;
      ALUOutM      <= '0;
      write_data_q <= '0;
      PCPlus4M     <= '0;
    end else if (!StallM) begin
      jumpM        <= jumpE;
      reg_write_q  <= RegWriteE;
      mem_write_q  <= MemWriteE;
      MemtoRegM    <= MemtoRegE;
      WriteRegM    <= WriteRegE;
      ALUOutM      <= ALUMultOutE;
      write_data_q <= WriteDataE;
      PCPlus4M     <= PCPlus4E;
    end
  end

  // Last load data and the sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (load_done) rdata_q <= dmem_rdata;
      if (timeout || misalign) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: directed table, corner-case
// sequences and a randomized run against a behavioural model.
module tb_memory_stage;

  localparam int TO = 4;
`ifdef MEM_ALIGN_CHK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        jumpE, RegWriteE, MemWriteE;
  logic [2:0]  MemtoRegE;
  logic [4:0]  WriteRegE;
  logic [31:0] ALUMultOutE, WriteDataE, PCPlus4E;
  logic        jumpM, RegWriteM;
  logic [2:0]  MemtoRegM;
  logic [4:0]  WriteRegM;
  logic [31:0] ALUOutM, ReadDataM, PCPlus4M;
  logic        StallM, MemErrM;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_ready;

  always #5 clk = ~clk;

  memory_stage #(.TIMEOUT(TO), .CW(3)) dut (
    .clk(clk), .rst(rst),
    .jumpE(jumpE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
    .MemtoRegE(MemtoRegE), .WriteRegE(WriteRegE),
    .ALUMultOutE(ALUMultOutE), .WriteDataE(WriteDataE),
    .PCPlus4E(PCPlus4E),
    .jumpM(jumpM), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
    .WriteRegM(WriteRegM), .ALUOutM(ALUOutM), .ReadDataM(ReadDataM),
    .PCPlus4M(PCPlus4M), .StallM(StallM), .MemErrM(MemErrM),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_ready(dmem_ready)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic drive(input logic j, rw, mw, input logic [2:0] mtr,
                       input logic [4:0] wr, input logic [31:0] alu, wd,
                       pc4, input logic rdy, input logic [31:0] rd);
    jumpE = j; RegWriteE = rw; MemWriteE = mw; MemtoRegE = mtr;
    WriteRegE = wr; ALUMultOutE = alu; WriteDataE = wd;
    PCPlus4E = pc4; dmem_ready = rdy; dmem_rdata = rd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic rw, mw; logic [2:0] mtr; logic [4:0] wr;
    logic [31:0] alu, wd; logic rdy; logic [31:0] rdata;
    logic [31:0] e_alu; logic [4:0] e_wr;
    logic e_rw, e_we, e_req, e_stall;
    logic [31:0] e_rd, e_wd;
  } vec_t;

  vec_t tbl[8];

  typedef struct packed {
    logic j, rw, mw; logic [2:0] mtr; logic [4:0] wr;
    logic [31:0] alu, wd, pc4;
  } ins_t;

  ins_t        m;
  int          w;
  bit          err;
  logic [31:0] last;
  bit          memop, mis, acc, ab, x_req, x_stall, x_rw, ld, rst_now;
  logic [31:0] x_rd, tmp;
  logic        rdy;

  initial begin
    tbl[0] = '{1,0,3'd0,5'd5,32'h1234,0,0,0,
               0,0,0,0,0,0,0,0};
    tbl[1] = '{1,0,3'd1,5'd7,32'h40,0,0,0,
               32'h1234,5,1,0,0,0,0,0};
    tbl[2] = '{1,1,3'd0,5'd0,32'h80,32'hA5A5A5A5,1,32'hDEADBEEF,
               32'h40,7,1,0,1,0,32'hDEADBEEF,0};
    tbl[3] = '{1,0,3'd0,5'd9,32'h55,0,0,0,
               32'h80,0,0,1,1,1,32'hDEADBEEF,32'hA5A5A5A5};
    tbl[4] = '{1,0,3'd0,5'd10,32'h66,0,0,32'h12345678,
               32'h80,0,0,1,1,1,32'hDEADBEEF,32'hA5A5A5A5};
    tbl[5] = '{1,0,3'd0,5'd11,32'h77,0,0,0,
               32'h80,0,0,1,1,1,32'hDEADBEEF,32'hA5A5A5A5};
    tbl[6] = '{1,0,3'd0,5'd12,32'h88,0,1,32'hCAFEF00D,
               32'h80,0,1,1,1,0,32'hDEADBEEF,32'hA5A5A5A5};
    tbl[7] = '{0,0,3'd0,5'd0,0,0,0,0,
               32'h88,12,1,0,0,0,32'hDEADBEEF,0};

    drive(0,0,0,3'd0,5'd0,0,0,0,0,0);
    rst = 1'b1;
    step(); step();
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      drive(0, tbl[i].rw, tbl[i].mw, tbl[i].mtr, tbl[i].wr,
            tbl[i].alu, tbl[i].wd, 0, tbl[i].rdy, tbl[i].rdata);
      @(negedge clk);
      chk($sformatf("t%0d_alu", i), ALUOutM, tbl[i].e_alu);
      chk($sformatf("t%0d_addr", i), dmem_addr, tbl[i].e_alu);
      chk($sformatf("t%0d_wr", i), 32'(WriteRegM), 32'(tbl[i].e_wr));
      chk($sformatf("t%0d_rw", i), 32'(RegWriteM), 32'(tbl[i].e_rw));
      chk($sformatf("t%0d_we", i), 32'(dmem_we), 32'(tbl[i].e_we));
      chk($sformatf("t%0d_req", i), 32'(dmem_req), 32'(tbl[i].e_req));
      chk($sformatf("t%0d_stall", i), 32'(StallM),
          32'(tbl[i].e_stall));
      chk($sformatf("t%0d_rd", i), ReadDataM, tbl[i].e_rd);
      chk($sformatf("t%0d_wd", i), dmem_wdata, tbl[i].e_wd);
      chk($sformatf("t%0d_err", i), 32'(MemErrM), 0);
      step();
    end

    // timeout: memory never answers
    drive(0,1,0,3'd1,5'd3,32'h100,0,32'h104,0,0);
    step();
    drive(0,0,0,3'd0,5'd0,0,0,0,0,0);
    for (int k = 0; k < TO; k++) begin
      @(negedge clk);
      chk($sformatf("to_stall%0d", k), 32'(StallM), 1);
      chk($sformatf("to_rw%0d", k), 32'(RegWriteM), 0);
      chk($sformatf("to_addr%0d", k), dmem_addr, 32'h100);
      step();
    end
    @(negedge clk);
    chk("to_end_stall", 32'(StallM), 0);
    chk("to_end_req", 32'(dmem_req), 0);
    chk("to_end_rw", 32'(RegWriteM), 0);
    chk("to_end_err", 32'(MemErrM), 0);
    step();
    for (int k = 0; k < 3; k++) begin
      drive(0,1,0,3'd0,5'(k + 1),32'(k),0,0,0,0);
      @(negedge clk);
      chk($sformatf("to_sticky%0d", k), 32'(MemErrM), 1);
      step();
    end

    // reset in the second wait cycle of a load
    drive(1,1,0,3'd1,5'd6,32'h200,0,32'h204,0,0);
    step();
    drive(0,0,0,3'd0,5'd0,0,0,0,0,0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("rs_stall%0d", k), 32'(StallM), 1);
      if (k < 2) step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rs_req", 32'(dmem_req), 0);
    chk("rs_stall", 32'(StallM), 0);
    chk("rs_err", 32'(MemErrM), 0);
    chk("rs_ctl", 32'({jumpM, RegWriteM, MemtoRegM, WriteRegM}), 0);
    chk("rs_alu", ALUOutM, 0);
    chk("rs_pc4", PCPlus4M, 0);
    chk("rs_rd", ReadDataM, 0);
    step();

    // misaligned load
    drive(0,1,0,3'd1,5'd4,32'h42,0,0,0,0);
    step();
    drive(0,0,0,3'd0,5'd0,0,0,0,1,32'h11112222);
    @(negedge clk);
    chk("al_req", 32'(dmem_req), ALIGN ? 0 : 1);
    chk("al_addr", dmem_addr, 32'h42);
    chk("al_stall", 32'(StallM), 0);
    chk("al_rw", 32'(RegWriteM), ALIGN ? 0 : 1);
    chk("al_rd", ReadDataM, ALIGN ? 0 : 32'h11112222);
    step();
    drive(0,0,0,3'd0,5'd0,0,0,0,0,0);
    @(negedge clk);
    chk("al_err", 32'(MemErrM), ALIGN ? 1 : 0);
    step();

    // randomized run against the behavioural model
    rst = 1'b1;
    step();
    rst = 1'b0;
    m = '0; w = 0; err = 0; last = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tmp = $urandom;
      if ($urandom_range(0, 7) != 0) tmp[1:0] = 2'b00;
      rdy = ((cyc % 61) < 10) ? 1'b0 : 1'($urandom_range(0, 1));
      begin
        logic [2:0] mtr;
        mtr = 3'($urandom_range(0, 5));
        if (mtr == 3'd5) mtr = 3'd1;
        drive(1'($urandom), 1'($urandom),
              $urandom_range(0, 3) == 0, mtr, 5'($urandom), tmp,
              $urandom, $urandom, rdy, $urandom);
      end
      rst_now = ($urandom_range(0, 199) == 0);
      rst = rst_now;

      memop   = m.mw || (m.mtr == 3'd1);
      mis     = ALIGN && memop && (m.alu[1:0] != 2'b00);
      acc     = memop && !mis;
      ab      = acc && (w == TO);
      x_req   = acc && !ab;
      x_stall = x_req && !rdy;
      x_rw    = m.rw && !x_stall && !ab && !mis;
      ld      = (m.mtr == 3'd1);
      x_rd    = (x_req && rdy && ld) ? dmem_rdata : last;

      @(negedge clk);
      chk("r_ctl", 32'({jumpM, RegWriteM, MemtoRegM, WriteRegM}),
          32'({m.j, x_rw, m.mtr, m.wr}));
      chk("r_alu", ALUOutM, m.alu);
      chk("r_pc4", PCPlus4M, m.pc4);
      chk("r_rd", ReadDataM, x_rd);
      chk("r_mem", 32'({dmem_req, dmem_we, StallM, MemErrM}),
          32'({x_req, m.mw, x_stall, err}));
      chk("r_port", dmem_addr ^ {dmem_wdata[15:0], dmem_wdata[31:16]},
          m.alu ^ {m.wd[15:0], m.wd[31:16]});

      if (rst_now) begin
        m = '0; w = 0; err = 0; last = 0;
      end else if (x_stall) begin
        w++;
      end else begin
        if (ab || mis) err = 1;
        if (x_req && rdy && ld) last = dmem_rdata;
        m = '{jumpE, RegWriteE, MemWriteE, MemtoRegE, WriteRegE,
              ALUMultOutE, WriteDataE, PCPlus4E};
        w = 0;
      end
      step();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
